puck_motion: RTL

Frame-driven motion controller for the air-hockey puck, a 4x4 box on the 160x120 VGA field. On each frame tick it erases the box at its current position, pulses `collision_enable` to the collision checker, and consumes the returned `flip_horizontal`/`flip_vertical` flags. It then applies direction reversals, steps the position by one pixel per axis, and redraws the box. It sits between the frame-rate divider and the VGA adapter's plot port, and supplies the `x`/`y` that the collision checker inspects.

---
 rtl/puck_motion.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/puck_motion.sv
// puck_motion: frame-driven motion controller for the air-hockey puck.
// Each frame tick erases the 4x4 box, asks the collision checker for
// boundary flags, applies guarded direction reversals, steps the position
// by one pixel per axis and redraws the box. All outputs are registered;
// each pixel/strobe is launched on the edge that enters the state it
// belongs to, so the value is present for the whole of that state.
module puck_motion #(
    parameter int unsigned SCREEN_W    = 160,
    parameter int unsigned SCREEN_H    = 120,
    parameter int unsigned BOX         = 4,
    parameter int unsigned START_X     = 80,
    parameter int unsigned START_Y     = 60,
    parameter logic [2:0]  PUCK_COLOUR = 3'b111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       flip_horizontal,
    input  logic       flip_vertical,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       collision_enable,
    output logic       plot,
    output logic [7:0] px,
    output logic [6:0] py,
    output logic [2:0] colour,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] MAX_X = 8'(SCREEN_W - BOX);
    localparam logic [6:0] MAX_Y = 7'(SCREEN_H - BOX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_CHECK,
        S_APPLY,
        S_MOVE,
        S_DRAW
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic       r_dir_x;   // 1 = increasing x
    logic       r_dir_y;   // 1 = increasing y
    logic       r_ce;
    logic       r_plot;
    logic [7:0] r_px;
    logic [6:0] r_py;
    logic [2:0] r_colour;
    logic       r_busy;
    logic       r_done;

    logic [3:0] w_cnt_n;
    logic [7:0] w_px;
    logic [6:0] w_py;
    logic [7:0] w_nx;
    logic [6:0] w_ny;
    logic       w_ndx;
    logic       w_ndy;

    // Next box pixel address and next position with wall hold/invert.
    always_comb begin
        w_cnt_n = r_cnt + 4'd1;
        w_px    = r_x + {6'd0, w_cnt_n[1:0]};
        w_py    = r_y + {5'd0, w_cnt_n[3:2]};

        w_nx  = r_x;
        w_ndx = r_dir_x;
        if (r_dir_x) begin
            if (r_x == MAX_X) w_ndx = 1'b0;
            else              w_nx  = r_x + 8'd1;
        end else begin
            if (r_x == 8'd0)  w_ndx = 1'b1;
            else              w_nx  = r_x - 8'd1;
        end

        w_ny  = r_y;
        w_ndy = r_dir_y;
        if (r_dir_y) begin
            if (r_y == MAX_Y) w_ndy = 1'b0;
            else              w_ny  = r_y + 7'd1;
        end else begin
            if (r_y == 7'd0)  w_ndy = 1'b1;
            else              w_ny  = r_y - 7'd1;
        end
    end

    // Frame update sequencer with registered plot/handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_x      <= 8'(START_X);
            r_y      <= 7'(START_Y);
            r_dir_x  <= 1'b1;
            r_dir_y  <= 1'b1;
            r_ce     <= 1'b0;
            r_plot   <= 1'b0;
            r_px     <= '0;
            r_py     <= '0;
            r_colour <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        r_state  <= S_ERASE;
                        r_cnt    <= '0;
                        r_plot   <= 1'b1;
                        r_px     <= r_x;
                        r_py     <= r_y;
                        r_colour <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (r_cnt == 4'd15) begin
                        r_state <= S_CHECK;
                        r_cnt   <= '0;
                        r_plot  <= 1'b0;
                        r_ce    <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_n;
                        r_px  <= w_px;
                        r_py  <= w_py;
                    end
                end
                S_CHECK: begin
                    r_ce    <= 1'b0;
                    r_state <= S_APPLY;
                end
                S_APPLY: begin
                    // Flags only count when the box really sits on that wall.
                    if (flip_horizontal) begin
                        if (r_x == 8'd0)       r_dir_x <= 1'b1;
                        else if (r_x == MAX_X) r_dir_x <= 1'b0;
                    end
                    if (flip_vertical) begin
                        if (r_y == 7'd0)       r_dir_y <= 1'b1;
                        else if (r_y == MAX_Y) r_dir_y <= 1'b0;
                    end
                    r_state <= S_MOVE;
                end
                S_MOVE: begin
                    // First draw pixel is launched together with the new position.
                    r_x      <= w_nx;
                    r_y      <= w_ny;
                    r_dir_x  <= w_ndx;
                    r_dir_y  <= w_ndy;
                    r_state  <= S_DRAW;
                    r_cnt    <= '0;
                    r_plot   <= 1'b1;
                    r_px     <= w_nx;
                    r_py     <= w_ny;
                    r_colour <= PUCK_COLOUR;
                end
                S_DRAW: begin
                    if (r_cnt == 4'd15) begin
                        r_state  <= S_IDLE;
                        r_cnt    <= '0;
                        r_plot   <= 1'b0;
                        r_colour <= '0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_n;
                        r_px  <= w_px;
                        r_py  <= w_py;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign x                = r_x;
    assign y                = r_y;
    assign collision_enable = r_ce;
    assign plot             = r_plot;
    assign px               = r_px;
    assign py               = r_py;
    assign colour           = r_colour;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule
